// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin arbitrated adder: widths, FSM states
// and the rotating-priority search used to pick a requester.
package adder_arb_pkg;

   localparam int BITWIDTH_DEF = 8;
   localparam int NREQ_DEF     = 4;
   localparam int ID_W         = 2;
   localparam int COUNT_W      = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   // Returns {found, index}: first set bit at or above ptr, wrapping past the top.
   function automatic logic [ID_W:0] rr_pick(input logic [NREQ_DEF-1:0] valid,
                                             input logic [ID_W-1:0]     ptr);
      logic [ID_W:0]   res;
      logic [ID_W-1:0] idx;
      res = '0;
      idx = '0;
      for (int k = NREQ_DEF - 1; k >= 0; k--) begin
         idx = ptr + ID_W'(k);
         if (valid[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/adder_reg.sv
// Registered adder shared by all requesters; keeps the full carry-out and
// holds its result until cleared or loaded again.
module adder_reg
   import adder_arb_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEF
) (
   input  logic                iClk,
   input  logic                iArstN,
   input  logic                iEn,
   input  logic                iClr,
   input  logic [BITWIDTH-1:0] iA,
   input  logic [BITWIDTH-1:0] iB,
   output logic [BITWIDTH:0]   oSum
);

   logic [BITWIDTH:0] sum;

   // Clear wins over load so a synchronous reset always empties the result.
   always_ff @(posedge iClk or negedge iArstN) begin
      if (!iArstN) begin
         sum <= '0;
      end else if (iClr) begin
         sum <= '0;
      end else if (iEn) begin
         sum <= {1'b0, iA} + {1'b0, iB};
      end
   end

   assign oSum = sum;

endmodule

// File: rtl/adder_arb.sv
// Four requesters share one registered adder; a round-robin arbiter grants one
// request at a time and the result is presented until the consumer accepts it.
module adder_arb
   import adder_arb_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEF,
   parameter int NREQ     = NREQ_DEF
) (
   input  logic                     iClk,
   input  logic                     iRstN,
   input  logic [NREQ-1:0]          iReqValid,
   input  logic [NREQ*BITWIDTH-1:0] iReqData0,
   input  logic [NREQ*BITWIDTH-1:0] iReqData1,
   output logic [NREQ-1:0]          oReqReady,
   output logic                     oRspValid,
   output logic [ID_W-1:0]          oRspId,
   output logic [BITWIDTH:0]        oRspData,
   input  logic                     iRspReady,
   output logic                     oBusy,
   output logic [COUNT_W-1:0]       oOpCount
);

   state_t              state;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     id;
   logic [COUNT_W-1:0]  op_count;

   logic [ID_W:0]       pick;
   logic                found;
   logic [ID_W-1:0]     gnt;
   logic [BITWIDTH-1:0] op_a;
   logic [BITWIDTH-1:0] op_b;
   logic                add_en;
   logic                add_clr;
   logic                rsp_hs;
   logic [BITWIDTH:0]   sum;

   always_comb begin
      pick  = rr_pick(iReqValid, ptr);
      found = pick[ID_W];
      gnt   = pick[ID_W-1:0];
      op_a  = iReqData0[int'(gnt)*BITWIDTH +: BITWIDTH];
      op_b  = iReqData1[int'(gnt)*BITWIDTH +: BITWIDTH];
   end

   // Gating with iRstN keeps a grant from being offered while reset is held.
   always_comb begin
      add_en  = iRstN && (state == ST_IDLE) && found;
      rsp_hs  = (state == ST_RESP) && iRspReady;
      add_clr = !iRstN || rsp_hs;
   end

   always_comb begin
      oReqReady = '0;
      if (add_en) begin
         oReqReady[gnt] = 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         id       <= '0;
         op_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  id    <= gnt;
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Priority rotates past the requester just served.
               if (iRspReady) begin
                  ptr      <= id + ID_W'(1);
                  op_count <= op_count + COUNT_W'(1);
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Async reset tied off; all clearing arrives synchronously through iClr.
   adder_reg #(
      .BITWIDTH (BITWIDTH)
   ) u_adder_reg (
      .iClk   (iClk),
      .iArstN (1'b1),
      .iEn    (add_en),
      .iClr   (add_clr),
      .iA     (op_a),
      .iB     (op_b),
      .oSum   (sum)
   );

   assign oRspValid = (state == ST_RESP);
   assign oRspId    = id;
   assign oRspData  = sum;
   assign oBusy     = (state != ST_IDLE);
   assign oOpCount  = op_count;

endmodule

// File: tb/tb_adder_arb.sv
// Directed and random stimulus for adder_arb compared against a transaction-level
// model of the arbiter (pending response, rotating pointer, op counter).
module tb_adder_arb;

   logic        iClk = 1'b0;
   logic        iRstN;
   logic [3:0]  iReqValid;
   logic [31:0] iReqData0;
   logic [31:0] iReqData1;
   logic [3:0]  oReqReady;
   logic        oRspValid;
   logic [1:0]  oRspId;
   logic [8:0]  oRspData;
   logic        iRspReady;
   logic        oBusy;
   logic [15:0] oOpCount;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit m_known = 0;
   bit m_pending;
   int m_ptr;
   int m_id;
   int m_data;
   int m_cnt;
   int grants[$];

   always #5 iClk = ~iClk;

   adder_arb dut (
      .iClk      (iClk),
      .iRstN     (iRstN),
      .iReqValid (iReqValid),
      .iReqData0 (iReqData0),
      .iReqData1 (iReqData1),
      .oReqReady (oReqReady),
      .oRspValid (oRspValid),
      .oRspId    (oRspId),
      .oRspData  (oRspData),
      .iRspReady (iRspReady),
      .oBusy     (oBusy),
      .oOpCount  (oOpCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // One clock: drive at negedge, compare everything against the model, then
   // advance the model by the edge that follows.
   task automatic cyc(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr, input logic rn);
      int g;
      logic [3:0] exp_ready;
      @(negedge iClk);
      iReqValid = v;
      iReqData0 = a;
      iReqData1 = b;
      iRspReady = rr;
      iRstN     = rn;
      #1;
      g = pick(v, m_ptr);
      exp_ready = 4'b0;
      if (rn && m_known && !m_pending && g >= 0) exp_ready[g] = 1'b1;
      if (!rn || m_known) chk("req_ready", 32'(oReqReady), 32'(exp_ready));
      if (m_known) begin
         chk("rsp_valid", 32'(oRspValid), 32'(m_pending));
         chk("busy", 32'(oBusy), 32'(m_pending));
         chk("rsp_data", 32'(oRspData), 32'(m_data));
         chk("rsp_id", 32'(oRspId), 32'(m_id));
         chk("op_count", 32'(oOpCount), 32'(m_cnt));
      end
      @(posedge iClk);
      if (!rn) begin
         m_known = 1; m_pending = 0; m_ptr = 0; m_id = 0; m_data = 0; m_cnt = 0;
      end else if (m_known && !m_pending && g >= 0) begin
         m_pending = 1;
         m_id = g;
         m_data = int'(a[g*8 +: 8]) + int'(b[g*8 +: 8]);
         grants.push_back(g);
      end else if (m_known && m_pending && rr) begin
         m_pending = 0;
         m_ptr = (m_id + 1) % 4;
         m_cnt = (m_cnt + 1) % 65536;
         m_data = 0;
      end
      #1;
   endtask

   initial begin
      int exp_order[5];
      iRstN = 1'b0; iReqValid = '0; iReqData0 = '0; iReqData1 = '0; iRspReady = 1'b0;

      // reset with junk on the inputs
      cyc(4'hF, $urandom, $urandom, 1'b1, 1'b0);
      cyc(4'hA, $urandom, $urandom, 1'b0, 1'b0);
      chk("reset_count", 32'(oOpCount), 32'h0);
      chk("reset_rsp_valid", 32'(oRspValid), 32'h0);

      // single request 0x12 + 0x34
      cyc(4'b0001, 32'h0000_0012, 32'h0000_0034, 1'b1, 1'b1);
      chk("single_data", 32'(oRspData), 32'h046);
      chk("single_id", 32'(oRspId), 32'h0);
      cyc(4'b0000, '0, '0, 1'b1, 1'b1);
      chk("single_count", 32'(oOpCount), 32'h1);
      cyc(4'b0000, '0, '0, 1'b1, 1'b1);

      // round robin from ptr=0 with all requesting
      cyc(4'b0000, '0, '0, 1'b1, 1'b0);
      grants.delete();
      for (int i = 0; i < 10; i++) cyc(4'b1111, $urandom, $urandom, 1'b1, 1'b1);
      exp_order = '{0, 1, 2, 3, 0};
      chk("rr_grant_count", 32'(grants.size()), 32'd5);
      for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(exp_order[i]));

      // backpressure with maximum operands
      cyc(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(4'hF, $urandom, $urandom, 1'b0, 1'b1);
         chk("bp_data", 32'(oRspData), 32'h1FE);
         chk("bp_busy", 32'(oBusy), 32'h1);
      end
      cyc(4'h0, '0, '0, 1'b1, 1'b1);
      chk("bp_release_idle", 32'(oBusy), 32'h0);

      // ptr is now 3; only requester 1 asks -> wraps past 3,0 to 1
      cyc(4'b0010, 32'h0000_0500, 32'h0000_0700, 1'b0, 1'b1);
      chk("wrap_id", 32'(oRspId), 32'h1);
      chk("wrap_data", 32'(oRspData), 32'h00C);
      cyc(4'b0000, '0, '0, 1'b1, 1'b1);
      cyc(4'b1111, $urandom, $urandom, 1'b0, 1'b1);
      chk("wrap_next_ptr", 32'(oRspId), 32'h2);

      // reset while a response is pending
      cyc(4'b0000, '0, '0, 1'b0, 1'b0);
      chk("rst_resp_valid", 32'(oRspValid), 32'h0);
      chk("rst_resp_data", 32'(oRspData), 32'h0);
      chk("rst_resp_count", 32'(oOpCount), 32'h0);
      cyc(4'b1111, $urandom, $urandom, 1'b1, 1'b1);
      chk("rst_resp_ptr", 32'(oRspId), 32'h0);

      // random traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         cyc(4'($urandom), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 60) != 0));
      end
      cyc(4'b0000, '0, '0, 1'b1, 1'b1);
      cyc(4'b0000, '0, '0, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 Parameter BITWIDTH, default 8 (from shared `define), operand width of the shared adder.
REQ-002 Parameter NREQ, fixed 4, number of requesters.
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRstN  input  1  reset, synchronous, active-low.
REQ-005 iReqValid  input  NREQ  per-requester request valid.
REQ-006 iReqData0  input  NREQ*BITWIDTH  packed operand A; requester i at bits [i*BITWIDTH +: BITWIDTH].
REQ-007 iReqData1  input  NREQ*BITWIDTH  packed operand B, same packing.
REQ-008 oReqReady  output  NREQ  one-hot request accept; combinational from state, pointer and iReqValid.
REQ-009 oRspValid  output  1  response valid.
REQ-010 oRspId  output  2  index of requester owning the response.
REQ-011 oRspData  output  BITWIDTH+1  sum including carry.
REQ-012 iRspReady  input  1  response accept.
REQ-013 oBusy  output  1  high whenever state is not IDLE.
REQ-014 oOpCount  output  16  count of completed response handshakes.

Function
REQ-015 FSM states: IDLE, RESP; reset state IDLE.
REQ-016 IDLE, no iReqValid bit set: oReqReady=0, stay IDLE, adder not enabled.
REQ-017 IDLE, any iReqValid set: grant g = first set bit searching upward from pointer ptr with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
REQ-018 Grant cycle: oReqReady[g]=1 only, adder iEn=1 with requester g operands, capture g into id register, next state RESP.
REQ-019 Request handshake = iReqValid[i] & oReqReady[i]; at most one per cycle.
REQ-020 Latency: request accepted cycle T, oRspValid=1 with oRspData=A+B from cycle T+1.
REQ-021 RESP: oRspValid=1, oRspData=adder output, oRspId=captured g; oReqReady=0; adder iEn=0 (result held).
REQ-022 RESP with iRspReady=0: hold all response outputs stable, stay RESP.
REQ-023 RESP with iRspReady=1: adder iClr=1, ptr <= (g+1) mod NREQ, oOpCount increments, next state IDLE.
REQ-024 No back-to-back: at least one IDLE cycle between responses; peak throughput one op per 2 cycles.
REQ-025 Sum width BITWIDTH+1; carry never dropped (0xFF+0xFF=0x1FE at BITWIDTH=8).
REQ-026 oOpCount wraps 0xFFFF -> 0x0000 without flag.
REQ-027 iReqValid changes during RESP ignored; pending requests re-arbitrated in next IDLE.
REQ-028 ptr changes only on response handshake.

Reset
REQ-029 iRstN=0 at a rising edge: state IDLE, ptr=0, id=0, oOpCount=0, adder result 0; dominates all other inputs.
REQ-030 Outputs during/after reset: oReqReady=0 while iRstN=0, oRspValid=0, oRspId=0, oRspData=0, oBusy=0.
REQ-031 Reset mid-RESP discards pending response; no count increment.
REQ-032 adder_reg async reset input tied inactive; its clear driven by iClr = ~iRstN | response handshake, keeping all reset synchronous.

Structure
REQ-033 BITWIDTH, NREQ and FSM state encodings in shared header adder_arb.def, which includes adder_reg.def for BITWIDTH.
REQ-034 Exactly one sub-module: adder_reg instance as the shared datapath; operand mux, arbiter, FSM, counter in adder_arb.

Verification (BITWIDTH=8)
REQ-035 Single request: iReqValid=0001, A=0x12, B=0x34, iRspReady=1 -> oReqReady=0001 in T, oRspValid=1, oRspData=0x046, oRspId=0 at T+1, oOpCount=1.
REQ-036 Round-robin: iReqValid=1111 held, iRspReady=1 -> grant order 0,1,2,3,0, one grant per 2 cycles.
REQ-037 Backpressure: A=0xFF, B=0xFF, iRspReady=0 for 5 cycles -> oRspData=0x1FE stable, oBusy=1, oReqReady=0; release -> IDLE next cycle.
REQ-038 Wrap skip: ptr=3, iReqValid=0010 -> grant 1, then ptr=2.
REQ-039 Reset in RESP: iRstN=0 one cycle -> oRspValid=0, oRspData=0, oOpCount=0, ptr=0 next cycle.
REQ-040 Counter wrap: 65536 completed ops -> oOpCount returns to 0x0000.
